// File: rtl/pac_man_cmd_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pac_man_cmd_gen: pushbutton sync/debounce to one-hot move pulses with repeat
// Revision: 1.0
// ----------------------------------------------------------------------------
module pac_man_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_key,
  input  logic       i_enable,
  output logic [3:0] o_command,
  output logic [3:0] o_held
);

  localparam int c_CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_TW   = $clog2(c_TMAX + 1);

  localparam logic [c_CW-1:0] c_CNT_LAST    = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE     = c_CW'(1);
  localparam logic [c_TW-1:0] c_DELAY_LOAD  = c_TW'(REPEAT_DELAY - 1);
  localparam logic [c_TW-1:0] c_PERIOD_LOAD = c_TW'(REPEAT_PERIOD - 1);
  localparam logic [c_TW-1:0] c_TMR_ONE     = c_TW'(1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DELAY  = 2'd1;
  localparam logic [1:0] c_REPEAT = 2'd2;

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] key_lvl;
  logic [3:0] held;
  logic [3:0] sel;

  // Released state is 1, so reset parks the synchroniser at "not pressed".
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= i_key;
      sync2_q <= sync1_q;
    end
  end

  assign key_lvl = ~sync2_q;

  for (genvar k = 0; k < 4; k++) begin : g_key
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic            held_q, held_d;

    always_comb begin
      cnt_d  = cnt_q;
      held_d = held_q;
      if (key_lvl[k] == held_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_CNT_LAST) begin
        held_d = ~held_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + c_CNT_ONE;
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        cnt_q  <= '0;
        held_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        held_q <= held_d;
      end
    end

    assign held[k] = held_q;
  end

  assign o_held = held;

  // Fixed priority up > down > left > right keeps the command one-hot.
  always_comb begin
    sel = 4'b0000;
    if (held[0])      sel = 4'b0001;
    else if (held[1]) sel = 4'b0010;
    else if (held[2]) sel = 4'b0100;
    else if (held[3]) sel = 4'b1000;
  end

  logic [1:0]      state_q, state_d;
  logic [3:0]      cur_q, cur_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [c_TW-1:0] timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    cmd_d   = 4'b0000;
    if (!i_enable) begin
      state_d = c_IDLE;
    end else begin
      case (state_q)
        c_IDLE: begin
          if (sel != 4'b0000) begin
            cmd_d   = sel;
            cur_d   = sel;
            timer_d = c_DELAY_LOAD;
            state_d = c_DELAY;
          end
        end
        c_DELAY, c_REPEAT: begin
          if (sel == 4'b0000) begin
            state_d = c_IDLE;
          end else if (sel != cur_q) begin
            cmd_d   = sel;
            cur_d   = sel;
            timer_d = c_DELAY_LOAD;
            state_d = c_DELAY;
          end else if (timer_q == '0) begin
            cmd_d   = cur_q;
            timer_d = c_PERIOD_LOAD;
            state_d = c_REPEAT;
          end else begin
            timer_d = timer_q - c_TMR_ONE;
          end
        end
        default: state_d = c_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= c_IDLE;
      cur_q   <= 4'b0000;
      cmd_q   <= 4'b0000;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cmd_q   <= cmd_d;
      timer_q <= timer_d;
    end
  end

  assign o_command = cmd_q;

endmodule
`default_nettype wire
